mdio_mmd_ctrl: RTL and testbench

MDIO_MMD_CTRL -- requirements
Module: mdio_mmd_ctrl

---
 rtl/mdio_mmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mdio_mmd_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_mmd_ctrl.sv
// Clause-45 MMD access over a clause-22 MDIO driver. Each request becomes four
// indirect-access operations through registers 0xD/0xE, with a per-operation timeout.
module mdio_mmd_ctrl #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535,
    parameter logic [4:0]  PHY_ADDR    = 5'h1f
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic [4:0]  req_mmd_i,
    input  logic [15:0] req_reg_i,
    input  logic [15:0] req_wdata_i,
    output logic        resp_vld_o,
    output logic        resp_err_o,
    output logic [15:0] resp_rdata_o,
    output logic        drv_valid_o,
    input  logic        drv_ready_i,
    output logic [1:0]  drv_cmd_o,
    output logic [25:0] drv_addr_o,
    output logic [15:0] drv_wdata_o,
    input  logic        drv_rdata_vld_i,
    input  logic [15:0] drv_rdata_i,
    output logic [2:0]  dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_RDWAIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [1:0]  op_idx;
    logic [15:0] tmo_cnt;
    logic        wr_q;
    logic [4:0]  mmd_q;
    logic [15:0] reg_q;
    logic [15:0] wdata_q;
    logic        accept;
    logic        tmo_hit;
    logic [22:0] first_op;
    logic [22:0] next_op;

    // Operation word: {cmd[1:0], clause-22 register[4:0], write data[15:0]}
    function automatic logic [22:0] op_word(input logic [1:0] idx, input logic wr,
                                            input logic [4:0] mmd, input logic [15:0] ra,
                                            input logic [15:0] wd);
        logic [22:0] w;
        case (idx)
            2'd0:    w = {2'b01, 5'h0d, 11'h000, mmd};
            2'd1:    w = {2'b01, 5'h0e, ra};
            2'd2:    w = {2'b01, 5'h0d, 2'b01, 9'h000, mmd};
            default: w = wr ? {2'b01, 5'h0e, wd} : {2'b10, 5'h0e, 16'h0000};
        endcase
        return w;
    endfunction

    // Both sides use valid/ready: a transfer happens on the rising edge where valid
    // and ready are both high; valid and payload stay stable until then.
    assign accept      = (state == S_IDLE) && req_valid_i && req_ready_o;
    assign tmo_hit     = (tmo_cnt == TIMEOUT_CYC - 16'd1);
    assign first_op    = op_word(2'd0, req_wr_i, req_mmd_i, req_reg_i, req_wdata_i);
    assign next_op     = op_word(op_idx + 2'd1, wr_q, mmd_q, reg_q, wdata_q);
    assign dbg_state_o = state;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_IDLE;
            op_idx       <= 2'd0;
            tmo_cnt      <= 16'd0;
            wr_q         <= 1'b0;
            mmd_q        <= 5'd0;
            reg_q        <= 16'd0;
            wdata_q      <= 16'd0;
            req_ready_o  <= 1'b0;
            resp_vld_o   <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= 16'd0;
            drv_valid_o  <= 1'b0;
            drv_cmd_o    <= 2'b00;
            drv_addr_o   <= 26'd0;
            drv_wdata_o  <= 16'd0;
        end else begin
            resp_vld_o   <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= 16'd0;
            case (state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (accept) begin
                        wr_q        <= req_wr_i;
                        mmd_q       <= req_mmd_i;
                        reg_q       <= req_reg_i;
                        wdata_q     <= req_wdata_i;
                        op_idx      <= 2'd0;
                        tmo_cnt     <= 16'd0;
                        req_ready_o <= 1'b0;
                        drv_valid_o <= 1'b1;
                        drv_cmd_o   <= first_op[22:21];
                        drv_addr_o  <= {PHY_ADDR, first_op[20:16], 16'h0000};
                        drv_wdata_o <= first_op[15:0];
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (drv_ready_i) begin
                        drv_valid_o <= 1'b0;
                        tmo_cnt     <= 16'd0;
                        state       <= S_WAIT;
                    end else if (tmo_hit) begin
                        drv_valid_o <= 1'b0;
                        resp_vld_o  <= 1'b1;
                        resp_err_o  <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    // First WAIT cycle ignored: the driver may not have dropped ready yet
                    if (drv_ready_i && (tmo_cnt != 16'd0)) begin
                        tmo_cnt <= 16'd0;
                        if (op_idx != 2'd3) begin
                            op_idx      <= op_idx + 2'd1;
                            drv_valid_o <= 1'b1;
                            drv_cmd_o   <= next_op[22:21];
                            drv_addr_o  <= {PHY_ADDR, next_op[20:16], 16'h0000};
                            drv_wdata_o <= next_op[15:0];
                            state       <= S_ISSUE;
                        end else if (wr_q) begin
                            resp_vld_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            state <= S_RDWAIT;
                        end
                    end else if (tmo_hit) begin
                        resp_vld_o <= 1'b1;
                        resp_err_o <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_RDWAIT: begin
                    if (drv_rdata_vld_i) begin
                        resp_vld_o   <= 1'b1;
                        resp_rdata_o <= drv_rdata_i;
                        state        <= S_DONE;
                    end else if (tmo_hit) begin
                        resp_vld_o <= 1'b1;
                        resp_err_o <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    op_idx      <= 2'd0;
                    tmo_cnt     <= 16'd0;
                    req_ready_o <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_mmd_ctrl.sv
// Directed bench for mdio_mmd_ctrl: a behavioural MDIO driver logs every issued
// operation, and each scenario task checks the log and responses against constants.
`timescale 1ns/1ps
module tb_mdio_mmd_ctrl;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd2;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        req_valid_i, req_ready_o, req_wr_i;
    logic [4:0]  req_mmd_i;
    logic [15:0] req_reg_i, req_wdata_i;
    logic        resp_vld_o, resp_err_o;
    logic [15:0] resp_rdata_o;
    logic        drv_valid_o, drv_ready_i;
    logic [1:0]  drv_cmd_o;
    logic [25:0] drv_addr_o;
    logic [15:0] drv_wdata_o;
    logic        drv_rdata_vld_i;
    logic [15:0] drv_rdata_i;
    logic [2:0]  dbg_state_o;

    int checks = 0;
    int failures = 0;

    // Driver model controls (written by the main sequence only)
    int          drv_delay = 1;
    int          hang_after = -1;
    logic        spur_en = 1'b0;
    logic [15:0] rd_value = 16'h0;

    // Driver model observations
    logic [1:0]  cmd_log[$];
    logic [25:0] addr_log[$];
    logic [15:0] data_log[$];
    int ops_seen = 0;
    int gap_viol = 0;
    int hs_cyc = 0;

    // Response/accept monitor observations
    logic        resp_err_log[$];
    logic [15:0] resp_rdata_log[$];
    int resp_cnt = 0;
    int resp_cyc = 0;
    int accepts = 0;
    int acc_cyc = 0;
    int cyc = 0;

    mdio_mmd_ctrl #(.TIMEOUT_CYC(16'd100), .PHY_ADDR(5'h1f)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
        .req_mmd_i(req_mmd_i), .req_reg_i(req_reg_i), .req_wdata_i(req_wdata_i),
        .resp_vld_o(resp_vld_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
        .drv_valid_o(drv_valid_o), .drv_ready_i(drv_ready_i), .drv_cmd_o(drv_cmd_o),
        .drv_addr_o(drv_addr_o), .drv_wdata_o(drv_wdata_o),
        .drv_rdata_vld_i(drv_rdata_vld_i), .drv_rdata_i(drv_rdata_i),
        .dbg_state_o(dbg_state_o)
    );

    // Clock/reset
    always #5 clk = ~clk;
    initial forever @(posedge clk) cyc++;

    // Behavioural MDIO driver; drives at negedge, the DUT samples at posedge
    initial begin : drv_model
        int busy; int rd_lag; bit hung; bit hs_prev; bit rd_pend;
        busy = 0; rd_lag = 0; hung = 0; hs_prev = 0; rd_pend = 0;
        drv_ready_i = 1'b1; drv_rdata_vld_i = 1'b0; drv_rdata_i = 16'h0;
        forever begin
            @(negedge clk);
            drv_rdata_vld_i = 1'b0;
            drv_rdata_i = 16'h0;
            if (!rstn_i) begin
                busy = 0; hung = 0; hs_prev = 0; rd_pend = 0; drv_ready_i = 1'b1;
            end else begin
                if (hung && hang_after < 0) begin hung = 0; drv_ready_i = 1'b1; end
                if (hs_prev) begin
                    if (drv_valid_o) gap_viol++;
                    if (hung || drv_delay > 0) begin drv_ready_i = 1'b0; busy = drv_delay; end
                    if (spur_en && cmd_log[$] == 2'b01) begin
                        drv_rdata_vld_i = 1'b1; drv_rdata_i = 16'hDEAD;
                    end
                end else if (busy > 0 && !hung) begin
                    busy--;
                    if (busy == 0) drv_ready_i = 1'b1;
                end
                if (rd_pend) begin
                    rd_lag--;
                    if (rd_lag == 0) begin rd_pend = 0; drv_rdata_vld_i = 1'b1; drv_rdata_i = rd_value; end
                end
                hs_prev = drv_valid_o && drv_ready_i;
                if (hs_prev) begin
                    cmd_log.push_back(drv_cmd_o);
                    addr_log.push_back(drv_addr_o);
                    data_log.push_back(drv_wdata_o);
                    ops_seen++;
                    hs_cyc = cyc + 1;
                    if (hang_after >= 0 && ops_seen == hang_after) hung = 1;
                    if (drv_cmd_o == 2'b10) begin rd_pend = 1; rd_lag = drv_delay + 4; end
                end
            end
        end
    end

    initial begin : resp_mon
        forever begin
            @(negedge clk);
            if (resp_vld_o) begin
                resp_cnt++;
                resp_err_log.push_back(resp_err_o);
                resp_rdata_log.push_back(resp_rdata_o);
                resp_cyc = cyc;
            end
            if (req_valid_i && req_ready_o) begin accepts++; acc_cyc = cyc + 1; end
        end
    end

    // Driver tasks
    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic send_req(input logic wr, input logic [4:0] mmd, input logic [15:0] ra,
                            input logic [15:0] wd, output bit ok);
        int n;
        ok = 0; n = 0;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_wr_i = wr; req_mmd_i = mmd; req_reg_i = ra; req_wdata_i = wd;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (req_ready_o) ok = 1;
            n++;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(input int base, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (resp_cnt > base) ok = 1;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        tick();
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", req_ready_o); end
        checks++; if (drv_valid_o !== 1'b0 || drv_cmd_o !== 2'b00 || drv_addr_o !== 26'd0) begin
            failures++; $display("FAIL rst_drv: got valid=%b cmd=%b addr=%h expected all 0", drv_valid_o, drv_cmd_o, drv_addr_o); end
        checks++; if (resp_vld_o !== 1'b0 || resp_rdata_o !== 16'h0) begin
            failures++; $display("FAIL rst_resp: got vld=%b rdata=%h expected 0", resp_vld_o, resp_rdata_o); end
        checks++; if (dbg_state_o !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d expected %0d", dbg_state_o, ST_IDLE); end
        @(posedge clk); #1; rstn_i = 1'b1;
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready_pre_edge: got %b expected 0", req_ready_o); end
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready_rise: got %b expected 1", req_ready_o); end
    endtask

    task automatic test_write();
        int ob, rb; bit ok;
        logic [15:0] exp_q[$];
        logic [4:0]  exp_r[$];
        ob = ops_seen; rb = resp_cnt; drv_delay = 50;
        exp_q.push_back(16'h001f); exp_q.push_back(16'h0004); exp_q.push_back(16'h401f); exp_q.push_back(16'hA5A5);
        exp_r.push_back(5'h0d); exp_r.push_back(5'h0e); exp_r.push_back(5'h0d); exp_r.push_back(5'h0e);
        send_req(1'b1, 5'h1f, 16'h0004, 16'hA5A5, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_accept: got none expected acceptance"); end
        wait_resp(rb, 600, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_resp: got no resp_vld expected one"); end
        repeat (5) tick();
        checks++; if (ops_seen - ob !== 4) begin failures++; $display("FAIL wr_ops: got %0d expected 4", ops_seen - ob); end
        for (int i = 0; i < 4 && ob + i < ops_seen; i++) begin
            checks++; if (cmd_log[ob+i] !== 2'b01) begin failures++; $display("FAIL wr_cmd%0d: got %b expected 01", i, cmd_log[ob+i]); end
            checks++; if (addr_log[ob+i] !== {5'h1f, exp_r[i], 16'h0}) begin
                failures++; $display("FAIL wr_addr%0d: got %h expected %h", i, addr_log[ob+i], {5'h1f, exp_r[i], 16'h0}); end
            checks++; if (data_log[ob+i] !== exp_q[i]) begin failures++; $display("FAIL wr_data%0d: got %h expected %h", i, data_log[ob+i], exp_q[i]); end
        end
        checks++; if (resp_cnt - rb !== 1) begin failures++; $display("FAIL wr_resp_cnt: got %0d expected 1", resp_cnt - rb); end
        if (resp_cnt > rb) begin
            checks++; if (resp_err_log[rb] !== 1'b0 || resp_rdata_log[rb] !== 16'h0) begin
                failures++; $display("FAIL wr_resp_val: got err=%b rdata=%h expected err=0 rdata=0000", resp_err_log[rb], resp_rdata_log[rb]); end
        end
    endtask

    task automatic test_read();
        int ob, rb; bit ok;
        logic [15:0] exp_q[$];
        logic [1:0]  exp_c[$];
        ob = ops_seen; rb = resp_cnt; drv_delay = 3; rd_value = 16'h1234;
        exp_q.push_back(16'h0007); exp_q.push_back(16'h003c); exp_q.push_back(16'h4007); exp_q.push_back(16'h0000);
        exp_c.push_back(2'b01); exp_c.push_back(2'b01); exp_c.push_back(2'b01); exp_c.push_back(2'b10);
        send_req(1'b0, 5'h07, 16'h003c, 16'hFFFF, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rd_accept: got none expected acceptance"); end
        wait_resp(rb, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rd_resp: got no resp_vld expected one"); end
        checks++; if (ops_seen - ob !== 4) begin failures++; $display("FAIL rd_ops: got %0d expected 4", ops_seen - ob); end
        for (int i = 0; i < 4 && ob + i < ops_seen; i++) begin
            checks++; if (cmd_log[ob+i] !== exp_c[i] || data_log[ob+i] !== exp_q[i]) begin
                failures++; $display("FAIL rd_op%0d: got cmd=%b data=%h expected cmd=%b data=%h", i, cmd_log[ob+i], data_log[ob+i], exp_c[i], exp_q[i]); end
        end
        if (ops_seen - ob >= 4) begin
            checks++; if (addr_log[ob+3] !== {5'h1f, 5'h0e, 16'h0}) begin
                failures++; $display("FAIL rd_addr3: got %h expected %h", addr_log[ob+3], {5'h1f, 5'h0e, 16'h0}); end
        end
        if (resp_cnt > rb) begin
            checks++; if (resp_err_log[rb] !== 1'b0 || resp_rdata_log[rb] !== 16'h1234) begin
                failures++; $display("FAIL rd_resp_val: got err=%b rdata=%h expected err=0 rdata=1234", resp_err_log[rb], resp_rdata_log[rb]); end
        end
    endtask

    task automatic test_latency();
        int rb; bit ok;
        rb = resp_cnt; drv_delay = 0;
        send_req(1'b1, 5'h01, 16'h0100, 16'h0BEE, ok);
        wait_resp(rb, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lat_resp: got no resp_vld expected one"); end
        checks++; if (resp_cyc - acc_cyc !== 12) begin failures++; $display("FAIL lat_cycles: got %0d expected 12", resp_cyc - acc_cyc); end
        checks++; if (resp_vld_o !== 1'b1 || req_ready_o !== 1'b0) begin
            failures++; $display("FAIL lat_done: got vld=%b ready=%b expected vld=1 ready=0", resp_vld_o, req_ready_o); end
        tick();
        checks++; if (resp_vld_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++; $display("FAIL lat_idle: got vld=%b ready=%b expected vld=0 ready=1", resp_vld_o, req_ready_o); end
    endtask

    task automatic test_timeout();
        int ob, rb; bit ok;
        ob = ops_seen; rb = resp_cnt; drv_delay = 2; hang_after = ops_seen + 2;
        send_req(1'b1, 5'h03, 16'h0005, 16'h0001, ok);
        wait_resp(rb, 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL to_resp: got no resp_vld expected one"); end
        if (resp_cnt > rb) begin
            checks++; if (resp_err_log[rb] !== 1'b1 || resp_rdata_log[rb] !== 16'h0) begin
                failures++; $display("FAIL to_resp_val: got err=%b rdata=%h expected err=1 rdata=0000", resp_err_log[rb], resp_rdata_log[rb]); end
        end
        checks++; if (resp_cyc - hs_cyc !== 100) begin failures++; $display("FAIL to_cycles: got %0d expected 100", resp_cyc - hs_cyc); end
        repeat (5) tick();
        checks++; if (ops_seen - ob !== 2) begin failures++; $display("FAIL to_ops: got %0d expected 2", ops_seen - ob); end
        hang_after = -1;
        repeat (2) tick();
        ob = ops_seen; rb = resp_cnt;
        send_req(1'b1, 5'h04, 16'h0006, 16'h7777, ok);
        wait_resp(rb, 300, ok);
        checks++; if (!ok || resp_err_log[rb] !== 1'b0) begin failures++; $display("FAIL to_recover: got resp=%b expected clean response", ok); end
        checks++; if (ops_seen - ob !== 4) begin failures++; $display("FAIL to_recover_ops: got %0d expected 4", ops_seen - ob); end
        if (ops_seen - ob >= 4) begin
            checks++; if (data_log[ob+3] !== 16'h7777) begin failures++; $display("FAIL to_recover_data: got %h expected 7777", data_log[ob+3]); end
        end
    endtask

    task automatic test_back_to_back();
        int ob, rb, ab, gv, k, n; bit ok;
        logic [4:0]  mmd_t[3];
        logic [15:0] reg_t[3];
        logic [15:0] wd_t[3];
        mmd_t[0] = 5'h01; reg_t[0] = 16'h0011; wd_t[0] = 16'h1111;
        mmd_t[1] = 5'h02; reg_t[1] = 16'h0022; wd_t[1] = 16'h2222;
        mmd_t[2] = 5'h03; reg_t[2] = 16'h0033; wd_t[2] = 16'h3333;
        ob = ops_seen; rb = resp_cnt; ab = accepts; gv = gap_viol; drv_delay = 1;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_wr_i = 1'b1; req_mmd_i = mmd_t[0]; req_reg_i = reg_t[0]; req_wdata_i = wd_t[0];
        k = 0; n = 0;
        while (k < 3 && n < 600) begin
            @(negedge clk);
            if (req_ready_o) begin
                @(posedge clk); #1;
                k++;
                if (k < 3) begin req_mmd_i = mmd_t[k]; req_reg_i = reg_t[k]; req_wdata_i = wd_t[k]; end
                else req_valid_i = 1'b0;
            end
            n++;
        end
        req_valid_i = 1'b0;
        wait_resp(rb + 2, 300, ok);
        repeat (5) tick();
        checks++; if (k !== 3 || accepts - ab !== 3) begin failures++; $display("FAIL b2b_accepts: got %0d expected 3", accepts - ab); end
        checks++; if (resp_cnt - rb !== 3) begin failures++; $display("FAIL b2b_resps: got %0d expected 3", resp_cnt - rb); end
        checks++; if (ops_seen - ob !== 12) begin failures++; $display("FAIL b2b_ops: got %0d expected 12", ops_seen - ob); end
        checks++; if (gap_viol - gv !== 0) begin failures++; $display("FAIL b2b_gap: got %0d back-to-back valids expected 0", gap_viol - gv); end
        for (int j = 0; j < 3 && ob + 4*j + 3 < ops_seen; j++) begin
            checks++; if (data_log[ob+4*j] !== {11'h0, mmd_t[j]} || data_log[ob+4*j+1] !== reg_t[j] || data_log[ob+4*j+3] !== wd_t[j]) begin
                failures++; $display("FAIL b2b_seq%0d: got %h/%h/%h expected %h/%h/%h", j, data_log[ob+4*j], data_log[ob+4*j+1],
                                     data_log[ob+4*j+3], {11'h0, mmd_t[j]}, reg_t[j], wd_t[j]); end
        end
    endtask

    task automatic test_spurious();
        int ob, rb; bit ok;
        ob = ops_seen; rb = resp_cnt; drv_delay = 5; spur_en = 1'b1;
        send_req(1'b1, 5'h01, 16'h0002, 16'h00ff, ok);
        wait_resp(rb, 300, ok);
        spur_en = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL spur_resp: got no resp_vld expected one"); end
        checks++; if (ops_seen - ob !== 4) begin failures++; $display("FAIL spur_ops: got %0d expected 4", ops_seen - ob); end
        if (resp_cnt > rb) begin
            checks++; if (resp_err_log[rb] !== 1'b0 || resp_rdata_log[rb] !== 16'h0) begin
                failures++; $display("FAIL spur_rdata: got err=%b rdata=%h expected err=0 rdata=0000", resp_err_log[rb], resp_rdata_log[rb]); end
        end
    endtask

    task automatic test_reset_mid();
        int ob, rb, n; bit ok;
        ob = ops_seen; rb = resp_cnt; drv_delay = 30;
        send_req(1'b1, 5'h02, 16'h0010, 16'h5555, ok);
        n = 0;
        while (ops_seen < ob + 3 && n < 300) begin tick(); n++; end
        repeat (3) tick();
        checks++; if (dbg_state_o !== ST_WAIT || ops_seen - ob !== 3) begin
            failures++; $display("FAIL rm_pre: got state=%0d ops=%0d expected state=%0d ops=3", dbg_state_o, ops_seen - ob, ST_WAIT); end
        @(posedge clk); #2; rstn_i = 1'b0; #1;
        checks++; if (req_ready_o !== 1'b0 || drv_valid_o !== 1'b0 || drv_cmd_o !== 2'b00 || drv_addr_o !== 26'd0 || drv_wdata_o !== 16'h0) begin
            failures++; $display("FAIL rm_async: got ready=%b valid=%b cmd=%b addr=%h wdata=%h expected all 0",
                                 req_ready_o, drv_valid_o, drv_cmd_o, drv_addr_o, drv_wdata_o); end
        checks++; if (resp_vld_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin
            failures++; $display("FAIL rm_state: got vld=%b state=%0d expected vld=0 state=0", resp_vld_o, dbg_state_o); end
        repeat (3) @(posedge clk);
        #1; rstn_i = 1'b1;
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rm_ready_pre: got %b expected 0", req_ready_o); end
        @(negedge clk);
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rm_ready: got %b expected 1", req_ready_o); end
        repeat (10) tick();
        checks++; if (resp_cnt !== rb || ops_seen - ob !== 3) begin
            failures++; $display("FAIL rm_after: got resps=%0d ops=%0d expected resps=0 ops=3", resp_cnt - rb, ops_seen - ob); end
    endtask

    initial begin
        req_valid_i = 1'b0; req_wr_i = 1'b0; req_mmd_i = 5'h0; req_reg_i = 16'h0; req_wdata_i = 16'h0;
        repeat (3) @(posedge clk);
        test_reset();
        test_write();
        test_read();
        test_latency();
        test_timeout();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
